// File: rtl/shift_add_mult_if.sv
// Operand/result bundle for the shift-and-add multiplier: the requester drives
// start/a/b (master), the multiplier returns busy/done/product (slave).
interface shift_add_mult_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier retiring one multiplier bit per clock.
// Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module shift_add_mult #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   shift_add_mult_if.slave bus
);
   localparam int              CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH:0]     r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_product;

   logic                 w_load;
   logic                 w_step;
   logic                 w_finish;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_upper;
   logic [2*WIDTH:0]     w_acc_shift;
   logic [WIDTH-1:0]     w_mcand_ld;
   logic [WIDTH-1:0]     w_mplier_ld;
   logic [2*WIDTH-1:0]   w_result;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
   logic                 r_neg;
   logic                 w_neg_ld;

   // Magnitudes of the most negative value still fit in WIDTH unsigned bits.
   assign w_mcand_ld  = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
   assign w_mplier_ld = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
   assign w_neg_ld    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
   assign w_result    = r_neg ? (~w_acc_shift[2*WIDTH-1:0] + (2*WIDTH)'(1))
                              : w_acc_shift[2*WIDTH-1:0];

   // Sign of the result, captured alongside the operands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_neg <= 1'b0;
      end else if (w_load) begin
         r_neg <= w_neg_ld;
      end else begin
         r_neg <= r_neg;
      end
   end
`else
   assign w_mcand_ld  = bus.a;
   assign w_mplier_ld = bus.b;
   assign w_result    = w_acc_shift[2*WIDTH-1:0];
`endif

   // The upper field is WIDTH+1 bits so the carry of each partial sum survives the shift.
   assign w_sum       = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
   assign w_upper     = r_acc[0] ? w_sum : r_acc[2*WIDTH:WIDTH];
   assign w_acc_shift = {1'b0, w_upper, r_acc[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and datapath control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand capture, per-bit iteration and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mcand   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         if (w_load) begin
            r_mcand <= w_mcand_ld;
            r_acc   <= {(WIDTH + 1)'(0), w_mplier_ld};
            r_cnt   <= '0;
         end else if (w_step) begin
            r_mcand <= r_mcand;
            r_acc   <= w_acc_shift;
            r_cnt   <= r_cnt + CW'(1);
         end else begin
            r_mcand <= r_mcand;
            r_acc   <= r_acc;
            r_cnt   <= r_cnt;
         end
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_done    <= w_finish;
         r_product <= w_finish ? w_result : r_product;
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and randomized bench for shift_add_mult against an arithmetic reference.
module tb_shift_add_mult;
   localparam int W = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   checks  = 0;
   int   errors  = 0;

   shift_add_mult_if #(.WIDTH(W)) bus ();

   shift_add_mult #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y);
      longint p;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      p = longint'($signed(x)) * longint'($signed(y));
`else
      p = longint'(x) * longint'(y);
`endif
      return p[2*W-1:0];
   endfunction

   // One complete multiply: latency, result, operand-change immunity and done/busy fall.
   task automatic run_mult(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
      int   j;
      logic seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      chk($sformatf("%s_busy", tag), 64'(bus.busy), 64'd1);
      j    = 0;
      seen = 1'b0;
      while (!seen && j < 30) begin
         @(negedge clk);
         j++;
         if (bus.done) seen = 1'b1;
      end
      chk($sformatf("%s_latency", tag), 64'(j), 64'(W));
      chk($sformatf("%s_product", tag), 64'(bus.product), 64'(ref_mult(x, y)));
      @(negedge clk);
      chk($sformatf("%s_done_fall", tag), 64'(bus.done), 64'd0);
      chk($sformatf("%s_busy_fall", tag), 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int   npulse;
      logic busy_after;
      logic done_in_rst;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #2 reset_n = 1'b0;
      #1;
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_product", 64'(bus.product), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      run_mult(8'd13, 8'd11, "m13x11");
      chk("const_143", 64'(bus.product), 64'h008F);

      run_mult(8'd255, 8'd255, "m255x255");
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      chk("const_m1xm1", 64'(bus.product), 64'h0001);
`else
      chk("const_fe01", 64'(bus.product), 64'hFE01);
`endif
      repeat (3) @(negedge clk);
      chk("hold_idle", 64'(bus.product), 64'(ref_mult(8'd255, 8'd255)));

      run_mult(8'd0, 8'd200, "m0x200");
      chk("const_zero_a", 64'(bus.product), 64'h0000);
      run_mult(8'd200, 8'd0, "m200x0");
      chk("const_zero_b", 64'(bus.product), 64'h0000);

      // Start re-pulsed during RUN and DONE must be ignored.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'd6;
      bus.b     = 8'd7;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.a      = 8'd1;
      bus.b      = 8'd1;
      npulse     = 0;
      busy_after = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         if (bus.done) npulse++;
         if (j >= 9 && bus.busy) busy_after = 1'b1;
         if (j == 8) begin
            chk("restart_done_at8", 64'(bus.done), 64'd1);
            chk("restart_product", 64'(bus.product), 64'd42);
         end
         bus.start = (j == 3 || j == 7 || j == 8) ? 1'b1 : 1'b0;
      end
      chk("restart_pulses", 64'(npulse), 64'd1);
      chk("restart_no_rerun", 64'(busy_after), 64'd0);
      chk("restart_hold", 64'(bus.product), 64'(ref_mult(8'd6, 8'd7)));

      // Asynchronous reset mid-run abandons the multiply.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'd9;
      bus.b     = 8'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk("arst_product", 64'(bus.product), 64'd0);
      repeat (2) @(negedge clk);
      reset_n     = 1'b1;
      done_in_rst = 1'b0;
      busy_after  = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (bus.done) done_in_rst = 1'b1;
         if (bus.busy) busy_after = 1'b1;
      end
      chk("arst_no_done", 64'(done_in_rst), 64'd0);
      chk("arst_idle", 64'(busy_after), 64'd0);
      run_mult(8'd3, 8'd4, "m3x4");
      chk("const_12", 64'(bus.product), 64'd12);

      run_mult(8'h80, 8'h80, "m80x80");
      chk("const_4000", 64'(bus.product), 64'h4000);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      run_mult(8'hFD, 8'd5, "s_m3x5");
      chk("const_fff1", 64'(bus.product), 64'hFFF1);
      run_mult(8'h80, 8'h01, "s_m128x1");
      chk("const_ff80", 64'(bus.product), 64'hFF80);
`else
      run_mult(8'h80, 8'h01, "u_128x1");
      chk("const_0080", 64'(bus.product), 64'h0080);
`endif

      for (int n = 0; n < 20; n++) begin
         run_mult(W'($urandom), W'($urandom), $sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
